// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the SRAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr,
    output disp_gnt, disp_valid, disp_data,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output disp_req, disp_addr,
    input  disp_gnt, disp_valid, disp_data,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display has priority, a starvation counter forces
// the host through, and read data is routed back by an owner tag pipeline.
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 8
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic rd;
    logic host;
  } tag_t;

  logic [CNT_W-1:0]  starve_cnt;
  logic              host_starved;
  logic              disp_gnt;
  logic              host_gnt;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  tag_t              cmd_tag;
  tag_t              ret_tag;

  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  assign host_starved = (starve_cnt == CNT_MAX);

  // Grants are combinational so a request can be serviced in the cycle it appears.
  always_comb begin
    disp_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!reset) begin
      if (bus.host_req && host_starved) host_gnt = 1'b1;
      else if (bus.disp_req)            disp_gnt = 1'b1;
      else if (bus.host_req)            host_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (bus.host_req && !host_gnt) begin
      if (!host_starved) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Command stage; address/data hold when idle to keep the RAM bus quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_tag   <= '0;
    end else begin
      mem_en       <= disp_gnt | host_gnt;
      mem_we       <= host_gnt & bus.host_we;
      cmd_tag.rd   <= disp_gnt | (host_gnt & ~bus.host_we);
      cmd_tag.host <= host_gnt;
      if (host_gnt) begin
        mem_addr  <= bus.host_addr;
        mem_wdata <= bus.host_wdata;
      end else if (disp_gnt) begin
        mem_addr  <= bus.disp_addr;
      end
    end
  end

  // Return stage: ret_tag lines up with MEM_RDATA, then data lands in the owner's register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_tag     <= '0;
      disp_valid  <= 1'b0;
      host_rvalid <= 1'b0;
      disp_data   <= '0;
      host_rdata  <= '0;
    end else begin
      ret_tag     <= cmd_tag;
      disp_valid  <= ret_tag.rd & ~ret_tag.host;
      host_rvalid <= ret_tag.rd & ret_tag.host;
      if (ret_tag.rd && !ret_tag.host) disp_data  <= bus.mem_rdata;
      if (ret_tag.rd &&  ret_tag.host) host_rdata <= bus.mem_rdata;
    end
  end

  assign bus.disp_gnt    = disp_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.disp_valid  = disp_valid;
  assign bus.disp_data   = disp_data;
  assign bus.host_rvalid = host_rvalid;
  assign bus.host_rdata  = host_rdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a cycle-level reference model predicts
// grants, RAM commands and read returns; a negedge monitor checks them.
module tb_vram_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_prev = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // RAM model: registered read, data defaults to the address low byte.
  logic [DW-1:0] ram    [logic [AW-1:0]];
  logic [DW-1:0] shadow [logic [AW-1:0]];

  function automatic logic [DW-1:0] shadow_rd(logic [AW-1:0] a);
    if (shadow.exists(a)) return shadow[a];
    return a[DW-1:0];
  endfunction

  initial bus.mem_rdata = '0;
  always @(posedge clk) begin
    rst_prev <= reset;
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
      else bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : bus.mem_addr[DW-1:0];
    end
  end

  typedef struct {
    bit            host;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  rsp_t rsp_q[$];
  rsp_t r;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int wait_cnt = 0;
  bit exp_dg = 0, exp_hg = 0;
  bit pend_v = 0, pend_we = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_wd = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    chk("mem_en", bus.mem_en, pend_v);
    if (pend_v) begin
      chk("mem_we", bus.mem_we, pend_we);
      chk("mem_addr", bus.mem_addr, pend_addr);
      if (pend_we) chk("mem_wdata", bus.mem_wdata, pend_wd);
    end

    if (bus.disp_valid || bus.host_rvalid) begin
      chk("single_valid", bus.disp_valid & bus.host_rvalid, 0);
      if (rsp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_valid: got disp_valid=%0b host_rvalid=%0b expected none (cycle %0d)",
                 bus.disp_valid, bus.host_rvalid, cyc);
      end else begin
        r = rsp_q.pop_front();
        chk("valid_owner_host", bus.host_rvalid, r.host);
        chk("rsp_data", r.host ? bus.host_rdata : bus.disp_data, r.data);
        chk("rsp_latency", cyc, r.due);
      end
    end else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      vecs++;
      errs++;
      $display("FAIL missing_valid: got no valid expected one due cycle %0d (cycle %0d)", r.due, cyc);
    end

    if (rst_prev) begin
      chk("rst_disp_valid", bus.disp_valid, 0);
      chk("rst_host_rvalid", bus.host_rvalid, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_disp_data", bus.disp_data, 0);
      chk("rst_host_rdata", bus.host_rdata, 0);
    end

    // Reference arbitration: host wins when starved or when the display is idle.
    if (reset) begin
      exp_hg = 0;
      exp_dg = 0;
    end else begin
      exp_hg = bus.host_req && (wait_cnt == SL || !bus.disp_req);
      exp_dg = bus.disp_req && !exp_hg;
    end
    chk("disp_gnt", bus.disp_gnt, exp_dg);
    chk("host_gnt", bus.host_gnt, exp_hg);

    if (reset) begin
      rsp_q.delete();
      pend_v   = 0;
      wait_cnt = 0;
    end else begin
      pend_v = exp_dg || exp_hg;
      if (exp_hg) begin
        pend_we   = bus.host_we;
        pend_addr = bus.host_addr;
        pend_wd   = bus.host_wdata;
      end else if (exp_dg) begin
        pend_we   = 0;
        pend_addr = bus.disp_addr;
      end
      if (pend_v && !pend_we) rsp_q.push_back('{host: exp_hg, data: shadow_rd(pend_addr), due: cyc + 3});
      if (pend_v && pend_we) shadow[pend_addr] = pend_wd;
      if (bus.host_req && !exp_hg) wait_cnt = (wait_cnt < SL) ? wait_cnt + 1 : SL;
      else wait_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.disp_req   = 1'b1;
    bus.disp_addr  = '0;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 16'h0100;
    bus.host_wdata = '0;
    reset = 1'b1;
    repeat (3) step();

    // Display stream 0x0000..0x0009 straight out of reset.
    reset = 1'b0;
    bus.host_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.disp_addr = 16'(i);
      step();
    end
    bus.disp_req = 1'b0;
    repeat (5) step();

    // Host write then read-back with the display idle.
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 16'h1234;
    bus.host_wdata = 8'hA5;
    step();
    bus.host_we = 1'b0;
    step();
    bus.host_req = 1'b0;
    repeat (5) step();

    // Starvation: both requesters stream reads.
    bus.disp_req  = 1'b1;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.disp_addr = 16'h0040;
    bus.host_addr = 16'h1234;
    for (int i = 0; i < 30; i++) begin
      step();
      if (exp_dg) bus.disp_addr = bus.disp_addr + 1'b1;
      if (exp_hg) bus.host_addr = 16'h0100 + 16'($urandom_range(0, 31));
    end
    bus.disp_req = 1'b0;
    bus.host_req = 1'b0;
    repeat (5) step();

    // Reset with two display reads in flight, then starvation restarts from zero.
    bus.disp_req = 1'b1;
    bus.host_req = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (12) step();
    bus.disp_req = 1'b0;
    bus.host_req = 1'b0;
    repeat (5) step();

    // Randomized traffic; the host may move its address while still waiting.
    for (int i = 0; i < 800; i++) begin
      if (!bus.disp_req || exp_dg) begin
        bus.disp_req  = ($urandom_range(0, 3) != 0);
        bus.disp_addr = 16'($urandom);
      end
      if (!bus.host_req || exp_hg) begin
        bus.host_req   = ($urandom_range(0, 2) == 0);
        bus.host_we    = 1'($urandom_range(0, 1));
        bus.host_addr  = 16'h0100 + 16'($urandom_range(0, 31));
        bus.host_wdata = 8'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        bus.host_addr = 16'h0100 + 16'($urandom_range(0, 31));
      end
      step();
    end
    bus.disp_req = 1'b0;
    bus.host_req = 1'b0;
    repeat (8) step();

    chk("scoreboard_drained", rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
